// File: rtl/led_fader.sv
// PWM LED driver that fades linearly between 0 and a runtime maximum
// whenever the blinker's binary LED level changes.
module led_fader #(
  parameter int CLK_FREQ_KHz = 50000,
  parameter int PWM_FREQ_Hz  = 1000,
  parameter int FADE_MS      = 250,
  parameter int BRIGHT_BITS  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   led_in,
  input  logic [BRIGHT_BITS-1:0] max_level,
  output logic                   pwm_out,
  output logic [BRIGHT_BITS-1:0] level,
  output logic                   busy
);

  function automatic int clog2(input longint value);
    longint v;
    int     r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam longint LEVELS   = longint'(1) << BRIGHT_BITS;
  localparam longint PRE_RAW  = (longint'(CLK_FREQ_KHz) * 1000) / (longint'(PWM_FREQ_Hz) * LEVELS);
  localparam longint STEP_RAW = (longint'(CLK_FREQ_KHz) * longint'(FADE_MS)) / (LEVELS - 1);
  localparam int     PRESCALE    = (PRE_RAW < 1) ? 1 : int'(PRE_RAW);
  localparam int     STEP_CYCLES = (STEP_RAW < 1) ? 1 : int'(STEP_RAW);
  localparam int     PRE_W  = (clog2(longint'(PRESCALE)) < 1) ? 1 : clog2(longint'(PRESCALE));
  localparam int     STEP_W = (clog2(longint'(STEP_CYCLES)) < 1) ? 1 : clog2(longint'(STEP_CYCLES));

  localparam logic [PRE_W-1:0]       PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [STEP_W-1:0]      STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [BRIGHT_BITS-1:0] PWM_LAST  = BRIGHT_BITS'(LEVELS - 2);
  localparam logic [BRIGHT_BITS-1:0] LVL_MAX   = {BRIGHT_BITS{1'b1}};

  typedef enum logic [1:0] {
    ST_STEADY    = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2
  } state_t;

  function automatic logic [BRIGHT_BITS-1:0] sat_inc(input logic [BRIGHT_BITS-1:0] v);
    return (v == LVL_MAX) ? v : v + BRIGHT_BITS'(1);
  endfunction

  function automatic logic [BRIGHT_BITS-1:0] sat_dec(input logic [BRIGHT_BITS-1:0] v);
    return (v == '0) ? v : v - BRIGHT_BITS'(1);
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [BRIGHT_BITS-1:0] r_level;
  logic [BRIGHT_BITS-1:0] w_level_nxt;
  logic [STEP_W-1:0]      r_step_cnt;
  logic [STEP_W-1:0]      w_step_nxt;
  logic                   r_busy;
  logic [BRIGHT_BITS-1:0] w_target;
  logic [BRIGHT_BITS-1:0] w_lvl_inc;
  logic [BRIGHT_BITS-1:0] w_lvl_dec;
  logic                   w_step_wrap;

  logic [PRE_W-1:0]       r_pre_cnt;
  logic [BRIGHT_BITS-1:0] r_pwm_cnt;
  logic                   r_pwm_out;
  logic                   w_pwm_tick;

  // Ramp control: decide next state, step counter and level
  always_comb begin
    w_target    = led_in ? max_level : '0;
    w_lvl_inc   = sat_inc(r_level);
    w_lvl_dec   = sat_dec(r_level);
    w_step_wrap = (r_step_cnt == STEP_LAST);
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_step_nxt  = '0;
    case (r_state)
      ST_STEADY: begin
        if (r_level < w_target) begin
          w_state_nxt = ST_RAMP_UP;
        end else if (r_level > w_target) begin
          w_state_nxt = ST_RAMP_DOWN;
        end
      end
      ST_RAMP_UP: begin
        if (r_level == w_target) begin
          w_state_nxt = ST_STEADY;
        end else if (r_level > w_target) begin
          w_state_nxt = ST_RAMP_DOWN;
        end else if (w_step_wrap) begin
          w_level_nxt = w_lvl_inc;
          if (w_lvl_inc == w_target) begin
            w_state_nxt = ST_STEADY;
          end
        end else begin
          w_step_nxt = r_step_cnt + STEP_W'(1);
        end
      end
      ST_RAMP_DOWN: begin
        if (r_level == w_target) begin
          w_state_nxt = ST_STEADY;
        end else if (r_level < w_target) begin
          w_state_nxt = ST_RAMP_UP;
        end else if (w_step_wrap) begin
          w_level_nxt = w_lvl_dec;
          if (w_lvl_dec == w_target) begin
            w_state_nxt = ST_STEADY;
          end
        end else begin
          w_step_nxt = r_step_cnt + STEP_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_STEADY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_STEADY;
      r_level    <= '0;
      r_step_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_step_cnt <= w_step_nxt;
      r_busy     <= (w_state_nxt != ST_STEADY);
    end
  end

  // PWM stage: free-running prescaler and frame counter, registered compare
  assign w_pwm_tick = (r_pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
      r_pwm_out <= 1'b0;
    end else begin
      r_pre_cnt <= w_pwm_tick ? '0 : r_pre_cnt + PRE_W'(1);
      if (w_pwm_tick) begin
        r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + BRIGHT_BITS'(1);
      end
      r_pwm_out <= (r_pwm_cnt < r_level);
    end
  end

  assign pwm_out = r_pwm_out;
  assign level   = r_level;
  assign busy    = r_busy;

endmodule
